// File: rtl/rob_pkg.sv
// Shared types and constants for the tagged reorder buffer.
// Holds the per-entry record layout, default widths and the PC step.
package rob_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_TAG_W  = 4;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_PC_W   = 32;
    localparam int ROB_RD_W   = 5;

    localparam logic [ROB_PC_W-1:0] PC_STEP = 4;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  is_sl;
        logic [ROB_PC_W-1:0]   pc;
        logic [ROB_PC_W-1:0]   jpc;
        logic [ROB_RD_W-1:0]   rd;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_operand_lookup.sv
// Operand readiness query for one tag, with same-cycle writeback bypass.
// In: slot state for the queried tag, ALU/SLB writeback. Out: ready, data.
module rob_operand_lookup #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic [TAG_W-1:0]  tag,
    input  logic              slot_valid,
    input  logic              slot_done,
    input  logic [DATA_W-1:0] slot_data,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              slb_valid,
    input  logic [TAG_W-1:0]  slb_tag,
    input  logic [DATA_W-1:0] slb_data,
    output logic              ready,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        ready = 1'b0;
        data  = '0;
        if (slot_valid) begin
            if (slot_done) begin
                ready = 1'b1;
                data  = slot_data;
            end else if (alu_valid && alu_tag == tag) begin
                ready = 1'b1;
                data  = alu_data;
            end else if (slb_valid && slb_tag == tag) begin
                ready = 1'b1;
                data  = slb_data;
            end
        end
    end

endmodule

// File: rtl/rob_tagged.sv
// Tag-addressed reorder buffer: dispatch at tail, writeback by tag,
// in-order commit at head, registered mispredict flush.
// Ports: dispatch (disp_*), ALU/SLB writeback, two operand queries,
// registered commit/flush outputs, occupancy (count/full/empty).
// Option ROB_PERF_CNT_EN adds perf_commit_cnt / perf_flush_cnt.
// Entry layout follows the rob_pkg widths; parameters must match them.
module rob_tagged
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int DATA_W = ROB_DATA_W,
    parameter int PC_W   = ROB_PC_W,
    parameter int RD_W   = ROB_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [PC_W-1:0]   disp_pc,
    input  logic [RD_W-1:0]   disp_rd,
    input  logic              disp_is_sl,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [PC_W-1:0]   alu_jpc,
    input  logic              slb_valid,
    input  logic [TAG_W-1:0]  slb_tag,
    input  logic [DATA_W-1:0] slb_data,
    input  logic [TAG_W-1:0]  q1_tag,
    output logic              q1_ready,
    output logic [DATA_W-1:0] q1_data,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q2_data,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [PC_W-1:0]   commit_pc,
    output logic [RD_W-1:0]   commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_is_sl,
    output logic              flush_valid,
    output logic [PC_W-1:0]   flush_pc,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commit_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    rob_entry_t       slots [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    rob_entry_t       head_e;
    logic             disp_fire;
    logic             commit_fire;
    logic             mispredict;
    logic             alu_ok;
    logic             slb_ok;

    always_comb begin
        full        = (count == (TAG_W+1)'(DEPTH));
        empty       = (count == '0);
        disp_ready  = !full && !flush_valid;
        disp_tag    = tail;
        disp_fire   = disp_valid && disp_ready;
        head_e      = slots[head];
        commit_fire = head_e.valid && head_e.done;
        mispredict  = commit_fire && (head_e.jpc != head_e.pc + PC_STEP);
        // Writebacks land only on live slots and never in the flush cycle.
        alu_ok      = alu_valid && !flush_valid && slots[alu_tag].valid;
        slb_ok      = slb_valid && !flush_valid && slots[slb_tag].valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_pc    <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
            commit_is_sl <= 1'b0;
            flush_valid  <= 1'b0;
            flush_pc     <= '0;
        end else begin
            commit_valid <= commit_fire;
            flush_valid  <= mispredict;
            if (commit_fire) begin
                commit_tag   <= head;
                commit_pc    <= head_e.pc;
                commit_rd    <= head_e.rd;
                commit_data  <= head_e.data;
                commit_is_sl <= head_e.is_sl;
            end
            if (mispredict) flush_pc <= head_e.jpc;
            if (alu_ok) begin
                slots[alu_tag].done <= 1'b1;
                slots[alu_tag].data <= alu_data;
                slots[alu_tag].jpc  <= alu_jpc;
            end
            if (slb_ok) begin
                slots[slb_tag].done <= 1'b1;
                slots[slb_tag].data <= slb_data;
            end
            if (mispredict) begin
                // Redirect: drop everything in flight, including this
                // edge's dispatch.
                for (int i = 0; i < DEPTH; i++) slots[i].valid <= 1'b0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (commit_fire) begin
                    slots[head].valid <= 1'b0;
                    head <= head + TAG_W'(1);
                end
                if (disp_fire) begin
                    slots[tail] <= '{valid: 1'b1, done: 1'b0,
                                     is_sl: disp_is_sl, pc: disp_pc,
                                     jpc: disp_pc + PC_STEP,
                                     rd: disp_rd, data: '0};
                    tail <= tail + TAG_W'(1);
                end
                unique case ({disp_fire, commit_fire})
                    2'b10:   count <= count + (TAG_W+1)'(1);
                    2'b01:   count <= count - (TAG_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    rob_operand_lookup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_q1 (
        .tag        (q1_tag),
        .slot_valid (slots[q1_tag].valid),
        .slot_done  (slots[q1_tag].done),
        .slot_data  (slots[q1_tag].data),
        .alu_valid  (alu_valid),
        .alu_tag    (alu_tag),
        .alu_data   (alu_data),
        .slb_valid  (slb_valid),
        .slb_tag    (slb_tag),
        .slb_data   (slb_data),
        .ready      (q1_ready),
        .data       (q1_data)
    );

    rob_operand_lookup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_q2 (
        .tag        (q2_tag),
        .slot_valid (slots[q2_tag].valid),
        .slot_done  (slots[q2_tag].done),
        .slot_data  (slots[q2_tag].data),
        .alu_valid  (alu_valid),
        .alu_tag    (alu_tag),
        .alu_data   (alu_data),
        .slb_valid  (slb_valid),
        .slb_tag    (slb_tag),
        .slb_data   (slb_data),
        .ready      (q2_ready),
        .data       (q2_data)
    );

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (commit_valid) perf_commit_cnt <= perf_commit_cnt + 32'd1;
            if (flush_valid)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_tagged.sv
// Self-checking bench for rob_tagged: directed table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_rob_tagged;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_valid, disp_ready, disp_is_sl;
    logic [31:0] disp_pc;
    logic [4:0]  disp_rd;
    logic [3:0]  disp_tag;
    logic        alu_valid, slb_valid;
    logic [3:0]  alu_tag, slb_tag;
    logic [31:0] alu_data, alu_jpc, slb_data;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_data, q2_data;
    logic        commit_valid, commit_is_sl, flush_valid;
    logic [3:0]  commit_tag;
    logic [31:0] commit_pc, commit_data, flush_pc;
    logic [4:0]  commit_rd;
    logic [4:0]  count;
    logic        full, empty;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    rob_tagged dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pc(disp_pc), .disp_rd(disp_rd),
        .disp_is_sl(disp_is_sl), .disp_tag(disp_tag),
        .alu_valid(alu_valid), .alu_tag(alu_tag),
        .alu_data(alu_data), .alu_jpc(alu_jpc),
        .slb_valid(slb_valid), .slb_tag(slb_tag), .slb_data(slb_data),
        .q1_tag(q1_tag), .q1_ready(q1_ready), .q1_data(q1_data),
        .q2_tag(q2_tag), .q2_ready(q2_ready), .q2_data(q2_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_pc(commit_pc), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_is_sl(commit_is_sl),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .count(count), .full(full), .empty(empty)
`ifdef ROB_PERF_CNT_EN
        , .perf_commit_cnt(perf_commit_cnt)
        , .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always @(posedge clk)
        if (rst && alu_valid && slb_valid)
            assert (alu_tag != slb_tag)
            else $error("FAIL wb_same_tag alu=%0d slb=%0d", alu_tag, slb_tag);

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        disp_valid = 0; disp_pc = 0; disp_rd = 0; disp_is_sl = 0;
        alu_valid = 0; alu_tag = 0; alu_data = 0; alu_jpc = 0;
        slb_valid = 0; slb_tag = 0; slb_data = 0;
        q1_tag = 0; q2_tag = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: in-order queue of live entries
    typedef struct {
        logic [3:0]  tag;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_sl;
        bit          done;
        logic [31:0] data;
        logic [31:0] jpc;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_tail;
    bit          m_flush;
    bit          e_cv, e_fv;
    ment_t       e_c;
    logic [31:0] e_fpc;

    function automatic int find(input logic [3:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_tail = 0; m_flush = 0; e_cv = 0; e_fv = 0; e_fpc = 0;
    endtask

    task automatic m_query(input logic [3:0] t, output bit r,
                           output logic [31:0] d);
        int i = find(t);
        r = 0; d = 0;
        if (i >= 0) begin
            if (mq[i].done) begin r = 1; d = mq[i].data; end
            else if (alu_valid && alu_tag == t) begin r = 1; d = alu_data; end
            else if (slb_valid && slb_tag == t) begin r = 1; d = slb_data; end
        end
    endtask

    task automatic m_step();
        bit    rdy = (mq.size() < 16) && !m_flush;
        bit    com = (mq.size() > 0) && mq[0].done;
        ment_t h;
        int    i;
        if (com) h = mq[0];
        if (!m_flush) begin
            i = find(alu_tag);
            if (alu_valid && i >= 0) begin
                mq[i].done = 1; mq[i].data = alu_data; mq[i].jpc = alu_jpc;
            end
            i = find(slb_tag);
            if (slb_valid && i >= 0) begin
                mq[i].done = 1; mq[i].data = slb_data;
            end
        end
        e_cv = com;
        if (com) e_c = h;
        e_fv = com && (h.jpc != h.pc + 32'd4);
        if (e_fv) begin
            e_fpc = h.jpc;
            mq.delete();
            m_tail = 0;
        end else begin
            if (com) void'(mq.pop_front());
            if (disp_valid && rdy) begin
                mq.push_back('{tag: 4'(m_tail), pc: disp_pc, rd: disp_rd,
                               is_sl: disp_is_sl, done: 0, data: 0,
                               jpc: disp_pc + 32'd4});
                m_tail = (m_tail + 1) % 16;
            end
        end
        m_flush = e_fv;
    endtask

    task automatic m_check_comb();
        bit          r;
        logic [31:0] d;
        chk("disp_ready", 32'(disp_ready),
            32'((mq.size() < 16) && !m_flush));
        chk("disp_tag", 32'(disp_tag), m_tail);
        m_query(q1_tag, r, d);
        chk("q1_ready", 32'(q1_ready), 32'(r));
        chk("q1_data", q1_data, d);
        m_query(q2_tag, r, d);
        chk("q2_ready", 32'(q2_ready), 32'(r));
        chk("q2_data", q2_data, d);
    endtask

    task automatic m_check_regs();
        chk("commit_valid", 32'(commit_valid), 32'(e_cv));
        if (e_cv) begin
            chk("commit_tag", 32'(commit_tag), 32'(e_c.tag));
            chk("commit_pc", commit_pc, e_c.pc);
            chk("commit_rd", 32'(commit_rd), 32'(e_c.rd));
            chk("commit_data", commit_data, e_c.data);
            chk("commit_is_sl", 32'(commit_is_sl), 32'(e_c.is_sl));
        end
        chk("flush_valid", 32'(flush_valid), 32'(e_fv));
        if (e_fv) chk("flush_pc", flush_pc, e_fpc);
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
    endtask

    function automatic logic [3:0] pick_tag();
        if (mq.size() > 0 && $urandom_range(4) != 0)
            return mq[$urandom_range(mq.size() - 1)].tag;
        return 4'($urandom_range(15));
    endfunction

    // ---------------- directed vector table
    typedef struct {
        int unsigned dv, pc, rd;
        int unsigned av, at, ad, aj;
        int unsigned sv, st, sd;
        int unsigned qt;
        int unsigned rdy, tag, qr, qd;
        int unsigned cv, crd, cd;
        int unsigned fv, fpc;
        int unsigned cnt;
    } vec_t;

    vec_t tv[$];

    initial begin
        // dv pc rd | av at ad aj | sv st sd | qt | rdy tag qr qd |
        // cv crd cd | fv fpc | cnt
        tv.push_back(vec_t'{1,'h100,5, 0,0,0,0, 0,0,0, 0, 1,0,0,0, 0,0,0, 0,0, 1});
        tv.push_back(vec_t'{0,0,0, 1,0,'h2A,'h104, 0,0,0, 0, 1,1,1,'h2A, 0,0,0, 0,0, 1});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 0, 1,1,1,'h2A, 1,5,'h2A, 0,0, 0});
        tv.push_back(vec_t'{1,'h10,1, 0,0,0,0, 0,0,0, 3, 1,1,0,0, 0,0,0, 0,0, 1});
        tv.push_back(vec_t'{1,'h14,2, 0,0,0,0, 0,0,0, 3, 1,2,0,0, 0,0,0, 0,0, 2});
        tv.push_back(vec_t'{1,'h18,3, 0,0,0,0, 0,0,0, 3, 1,3,0,0, 0,0,0, 0,0, 3});
        tv.push_back(vec_t'{0,0,0, 1,3,'h55,'h1C, 0,0,0, 3, 1,4,1,'h55, 0,0,0, 0,0, 3});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 3, 1,4,1,'h55, 0,0,0, 0,0, 3});
        tv.push_back(vec_t'{0,0,0, 1,2,'h22,'h18, 1,1,'h11, 2, 1,4,1,'h22, 0,0,0, 0,0, 3});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 1, 1,4,1,'h11, 1,1,'h11, 0,0, 2});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 2, 1,4,1,'h22, 1,2,'h22, 0,0, 1});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 3, 1,4,1,'h55, 1,3,'h55, 0,0, 0});
        tv.push_back(vec_t'{1,'h200,7, 0,0,0,0, 0,0,0, 4, 1,4,0,0, 0,0,0, 0,0, 1});
        tv.push_back(vec_t'{1,'h204,8, 1,4,'h77,'h300, 0,0,0, 4, 1,5,1,'h77, 0,0,0, 0,0, 2});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 4, 1,6,1,'h77, 1,7,'h77, 1,'h300, 0});
        tv.push_back(vec_t'{1,'h400,9, 1,5,'h99,'h208, 0,0,0, 5, 0,0,0,0, 0,0,0, 0,0, 0});
        tv.push_back(vec_t'{1,'h500,9, 0,0,0,0, 0,0,0, 5, 1,0,0,0, 0,0,0, 0,0, 1});
        tv.push_back(vec_t'{0,0,0, 1,0,5,'h504, 0,0,0, 0, 1,1,1,5, 0,0,0, 0,0, 1});
        tv.push_back(vec_t'{0,0,0, 0,0,0,0, 0,0,0, 0, 1,1,1,5, 1,9,5, 0,0, 0});
    end

    initial begin
        vec_t v;
        idle();
        // asynchronous reset state before any clock edge
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_flush_valid", 32'(flush_valid), 0);
        do_reset();
        #1;
        chk("rst_disp_ready", 32'(disp_ready), 1);

        // ---- table
        foreach (tv[k]) begin
            v = tv[k];
            @(negedge clk);
            disp_valid = (v.dv != 0); disp_pc = v.pc; disp_rd = 5'(v.rd);
            disp_is_sl = 0;
            alu_valid = (v.av != 0); alu_tag = 4'(v.at);
            alu_data = v.ad; alu_jpc = v.aj;
            slb_valid = (v.sv != 0); slb_tag = 4'(v.st); slb_data = v.sd;
            q1_tag = 4'(v.qt); q2_tag = 4'(v.qt);
            #1;
            chk($sformatf("v%0d_disp_ready", k), 32'(disp_ready), v.rdy);
            chk($sformatf("v%0d_disp_tag", k), 32'(disp_tag), v.tag);
            chk($sformatf("v%0d_q1_ready", k), 32'(q1_ready), v.qr);
            chk($sformatf("v%0d_q1_data", k), q1_data, v.qd);
            chk($sformatf("v%0d_q2_ready", k), 32'(q2_ready), v.qr);
            chk($sformatf("v%0d_q2_data", k), q2_data, v.qd);
            tick();
            chk($sformatf("v%0d_commit_valid", k), 32'(commit_valid), v.cv);
            if (v.cv != 0) begin
                chk($sformatf("v%0d_commit_rd", k), 32'(commit_rd), v.crd);
                chk($sformatf("v%0d_commit_data", k), commit_data, v.cd);
            end
            chk($sformatf("v%0d_flush_valid", k), 32'(flush_valid), v.fv);
            if (v.fv != 0)
                chk($sformatf("v%0d_flush_pc", k), flush_pc, v.fpc);
            chk($sformatf("v%0d_count", k), 32'(count), v.cnt);
        end
        @(negedge clk);
        idle();

        // ---- fill to full, commit frees one slot, tail wraps to 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            disp_valid = 1; disp_pc = 32'h1000 + 32'(i * 4);
            disp_rd = 5'(i);
            tick();
            @(negedge clk);
        end
        chk("full_flag", 32'(full), 1);
        chk("full_ready", 32'(disp_ready), 0);
        chk("full_count", 32'(count), 16);
        alu_valid = 1; alu_tag = 0; alu_data = 1; alu_jpc = 32'h1004;
        tick();
        chk("full_refuse_count", 32'(count), 16);
        @(negedge clk);
        alu_valid = 0;
        chk("full_no_bypass_ready", 32'(disp_ready), 0);
        tick();
        chk("full_commit_valid", 32'(commit_valid), 1);
        chk("full_after_commit_count", 32'(count), 15);
        chk("full_after_commit_full", 32'(full), 0);
        @(negedge clk);
        chk("wrap_ready", 32'(disp_ready), 1);
        chk("wrap_tag", 32'(disp_tag), 0);
        tick();
        chk("wrap_count", 32'(count), 16);
        @(negedge clk);
        idle();

        // ---- out-of-order completion, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1; disp_pc = 32'h40 + 32'(i * 4);
            disp_rd = 5'(10 + i);
            tick();
            @(negedge clk);
        end
        disp_valid = 0;
        for (int i = 2; i >= 0; i--) begin
            alu_valid = 1; alu_tag = 4'(i); alu_data = 32'(i + 100);
            alu_jpc = 32'h44 + 32'(i * 4);
            tick();
            chk($sformatf("ooo_wait%0d", i), 32'(commit_valid), 0);
            @(negedge clk);
        end
        alu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ooo_cv%0d", i), 32'(commit_valid), 1);
            chk($sformatf("ooo_tag%0d", i), 32'(commit_tag), 32'(i));
            chk($sformatf("ooo_data%0d", i), commit_data, 32'(i + 100));
            @(negedge clk);
        end
        tick();
        chk("ooo_done_cv", 32'(commit_valid), 0);
        chk("ooo_empty", 32'(empty), 1);
        @(negedge clk);

        // ---- async reset with count=7 and a mispredict about to commit
        do_reset();
        for (int i = 0; i < 7; i++) begin
            disp_valid = 1; disp_pc = 32'h80 + 32'(i * 4);
            disp_rd = 5'(i + 1);
            tick();
            @(negedge clk);
        end
        disp_valid = 0;
        alu_valid = 1; alu_tag = 0; alu_data = 32'hAB; alu_jpc = 32'h999;
        tick();
        chk("arst_pre_count", 32'(count), 7);
        @(negedge clk);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_commit_valid", 32'(commit_valid), 0);
        chk("arst_commit_data", commit_data, 0);
        chk("arst_flush_valid", 32'(flush_valid), 0);
        chk("arst_flush_pc", flush_pc, 0);
        tick();
        chk("arst_hold_flush", 32'(flush_valid), 0);
        chk("arst_hold_commit", 32'(commit_valid), 0);
        @(negedge clk);
        rst = 1'b1;

        // ---- randomized run against the reference model
        do_reset();
        m_reset();
        #1;
        m_check_regs();
        for (int c = 0; c < 4000; c++) begin
            int i;
            @(negedge clk);
            disp_valid = ($urandom_range(9) < 7);
            disp_pc    = $urandom & 32'hFFFF_FFFC;
            disp_rd    = 5'($urandom_range(31));
            disp_is_sl = 1'($urandom_range(1));
            alu_valid  = 1'($urandom_range(1));
            alu_tag    = pick_tag();
            alu_data   = $urandom;
            i = find(alu_tag);
            if (i >= 0 && $urandom_range(11) != 0)
                alu_jpc = mq[i].pc + 32'd4;
            else
                alu_jpc = $urandom;
            slb_valid  = 1'($urandom_range(1));
            slb_tag    = pick_tag();
            slb_data   = $urandom;
            if (slb_tag == alu_tag) slb_valid = 0;
            q1_tag     = pick_tag();
            q2_tag     = pick_tag();
            #1;
            m_check_comb();
            m_step();
            tick();
            m_check_regs();
        end
        @(negedge clk);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_tagged.md
Name: rob_tagged

Overview:
- Parametrised reorder buffer. Entries are addressed by tag (the slot index) rather than by searching on PC.
- Holds in-flight instructions between decode/register stage and commit. Accepts results from ALU and SLB by tag and answers two operand-readiness queries with same-cycle bypass.
- Commits in order, one per cycle. Raises a registered flush with the redirect PC on a mispredicted jump.
- Uses all DEPTH slots via an occupancy counter.

Parameters:
- DEPTH, 16, number of entries; power of two, >=2
- TAG_W, 4, log2(DEPTH)
- DATA_W, 32, result width
- PC_W, 32, PC width
- RD_W, 5, destination register index width

Ports:
- clk in 1: single clock, rising edge
- rst in 1: asynchronous, active-low reset
- disp_valid in 1: dispatch request
- disp_ready out 1: combinational, = !full && !flush_valid
- disp_pc in PC_W: instruction PC
- disp_rd in RD_W: destination register
- disp_is_sl in 1: load/store flag, stored per entry
- disp_tag out TAG_W: tail tag allocated on handshake
- alu_valid in 1, alu_tag in TAG_W, alu_data in DATA_W, alu_jpc in PC_W: ALU writeback
- slb_valid in 1, slb_tag in TAG_W, slb_data in DATA_W: SLB writeback
- q1_tag in TAG_W, q1_ready out 1, q1_data out DATA_W: operand query 1
- q2_tag, q2_ready, q2_data: operand query 2, same widths as query 1
- commit_valid out 1, commit_tag out TAG_W, commit_pc out PC_W, commit_rd out RD_W, commit_data out DATA_W, commit_is_sl out 1: registered commit
- flush_valid out 1, flush_pc out PC_W: registered mispredict flush
- count out TAG_W+1, full out 1, empty out 1: occupancy

Behaviour:
- Reset (rst=0, async): head=tail=count=0; all entry valid/done=0. All registered outputs 0. empty=1, full=0.
- Per entry: valid, done, is_sl, pc, jpc, rd, data.
- Dispatch:
  - On disp_valid && disp_ready at an edge, write slot[tail]: valid=1, done=0, jpc=disp_pc+4 (mod 2^PC_W).
  - tail increments, wrapping at DEPTH. disp_tag = tail before the edge.
  - No full-bypass: with full=1, dispatch is refused even if a commit happens that cycle.
- Writeback:
  - ALU sets done=1, data and jpc of slot[alu_tag]. SLB sets done=1 and data of slot[slb_tag]; jpc stays pc+4.
  - Writeback to a slot with valid=0 is ignored. ALU and SLB to different tags in one cycle both apply.
  - ALU and SLB to the same tag in one cycle is illegal; the bench asserts against it.
- Query (combinational), priority order:
  - valid slot with done=1 -> ready=1, data=stored value.
  - otherwise a same-cycle alu/slb writeback whose tag matches -> ready=1, data from that port; ALU wins a match.
  - otherwise ready=0, data=0.
  - Slot with valid=0 -> ready=0, data=0.
- Commit:
  - If slot[head] valid && done at an edge: commit_* register that entry, commit_valid=1 for one cycle; slot valid cleared; head increments. Otherwise commit_valid=0.
  - Latency: writeback edge to earliest commit_valid is 1 cycle; a result that is not yet done cannot commit.
- Count:
  - +1 on dispatch, -1 on commit; unchanged when both happen.
  - full = (count==DEPTH); empty = (count==0).
- Flush:
  - On the commit edge where jpc != pc+4: commit_valid=1 and flush_valid=1, flush_pc=jpc, same cycle.
  - On that same edge: all slots invalidated, head=tail=count=0, and any same-edge dispatch is dropped.
  - While flush_valid=1: disp_ready=0 and writebacks are ignored. flush_valid lasts exactly one cycle.
- Reset mid-operation clears everything immediately, including a pending flush.

Optional Feature:
- ROB_PERF_CNT_EN defined: adds outputs perf_commit_cnt (32) and perf_flush_cnt (32).
  - Both reset to 0 and wrap at 2^32.
  - perf_commit_cnt increments on every commit_valid; perf_flush_cnt on every flush_valid.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rob_pkg: entry struct (valid, done, is_sl, pc, jpc, rd, data); default widths; helper constant PC_STEP=4.
- Sub-module rob_operand_lookup: combinational query with writeback bypass, instantiated twice (q1, q2).

Test Plan:
- Reset, then dispatch pc=0x100 rd=5 -> disp_tag=0, count=1. ALU wb tag0 data=0x2A jpc=0x104 -> next cycle commit_valid=1, rd=5, data=0x2A, flush_valid=0.
- Dispatch 16 with no writebacks -> full=1, disp_ready=0. Then complete tag0 -> after commit, count=15, full=0, and the next dispatch gets tag=0 (wrap).
- Out-of-order completion: dispatch tags 0,1,2; complete 2, then 1, then 0 -> commits in tag order 0,1,2 on consecutive cycles.
- Bypass: q1_tag=3 with alu_valid tag3 data=0x55 in the same cycle -> q1_ready=1, q1_data=0x55. Next cycle the stored value gives the same result.
- Mispredict: entry pc=0x200, ALU jpc=0x300 -> commit_valid=1, flush_valid=1, flush_pc=0x300. Next cycle count=0, empty=1, and a writeback issued during the flush cycle is ignored.
- Assert rst low while count=7 and a flush is pending -> all outputs 0, empty=1, immediately (asynchronously).
